uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the keyboard/serial input path. Generates the 16x oversample tick that paces the UART receive datapath, captures each completed byte into a 32-entry circular buffer, and presents buffered bytes to the CPU-side consumer over a valid/ready handshake. It tracks occupancy and overflow, and optionally gates delivery to whole lines.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: serial bit rate.
- `DEPTH`, default 32: buffer entries; must be a power of two, at least 4.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sample_tick`  out  1  one-cycle pulse at 16x BAUD_RATE, to the receive datapath.
- `rx_done`  in  1  one-cycle pulse from the receive datapath: byte complete.
- `rx_data`  in  8  received byte; valid only while `rx_done` is high.
- `rd_valid`  out  1  head byte available to the consumer.
- `rd_ready`  in  1  consumer accepts the head byte.
- `rd_data`  out  8  head byte (show-ahead).
- `count`  out  $clog2(DEPTH)+1  number of stored bytes.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky: a byte was dropped.
- `ovf_clr`  in  1  one-cycle pulse that clears `overflow`.

## Operation
- Tick divider:
  - DIV = CLK_FREQ / (BAUD_RATE*16), integer floor, minimum 1.
  - The counter runs 0..DIV-1 and wraps.
  - `sample_tick` = 1 in the cycle the counter equals DIV-1.
  - Free-running after reset.
- Write path:
  - On `rx_done`, when not full or when a pop happens in the same cycle, store `rx_data` at `wr_ptr`.
  - `wr_ptr` increments modulo DEPTH.
- Read path:
  - Pop when `rd_valid && rd_ready`.
  - `rd_ptr` increments modulo DEPTH.
  - `rd_data` = mem[`rd_ptr`] at all times; undefined content when empty.
- `count`: +1 on write only, -1 on pop only, unchanged on both or neither.
- Overflow:
  - `rx_done` while full with no same-cycle pop: byte dropped, `overflow` set.
  - When set and `ovf_clr` coincide, set wins.
- `rd_ready` while `rd_valid` = 0 is ignored. `rx_done` is not qualified by `sample_tick`.
- Reset mid-operation: buffer contents are discarded and the pointers are zeroed. Any in-flight `rx_done` in the reset cycle is lost.

## Timing
- Reset values: `sample_tick` 0, `rd_valid` 0, `count` 0, `full` 0, `overflow` 0, divider counter 0. `rd_data` is don't-care.
- Write latency: `rx_done` in cycle N gives `rd_valid` = 1 and the updated `count` in cycle N+1.
- The pop takes effect at the edge ending cycle N. The next head and the updated `count` appear in cycle N+1.
- `full`, `rd_valid` and `overflow` are registered or derived from registered state only; there is no combinational path from `rd_ready` or `rx_done`.
- At full, a simultaneous write and pop: both proceed, `count` stays DEPTH, no overflow.
- First `sample_tick` at cycle DIV-1 after reset release, then every DIV cycles.

## Configuration
- `UART_RX_CTRL_LINE_MODE_EN` defined:
  - `line_cnt` counts stored 0x0D bytes.
  - `rd_valid` = !empty && (`line_cnt` > 0 || `full`). The `full` term releases an overlong line.
  - Popping a 0x0D decrements `line_cnt`.
  - A received 0x08 is never stored. If the buffer is non-empty and the tail byte is not 0x0D, the tail is removed (`wr_ptr`-1, `count`-1). Otherwise the 0x08 is discarded. A discarded 0x08 does not set `overflow`.
  - 0x08 with a same-cycle pop: the removal and the pop both apply.
- Not defined: every byte is stored, and `rd_valid` = !empty.

## Test plan
- Reset, then `rx_done` with 0x41, 0x42, 0x43 → `count` 3; `rd_ready` held high → `rd_data` 0x41, 0x42, 0x43 on successive cycles; `count` 0; `rd_valid` 0.
- 32 writes of 0x00..0x1F → `full` 1. 33rd write of 0xFF → `overflow` 1 and `count` 32. Drain reads 0x00..0x1F. `ovf_clr` → `overflow` 0.
- At full, `rx_done` 0x55 and a pop in the same cycle → `count` 32, no overflow, 0x55 read last.
- CLK_FREQ 100_000_000, BAUD_RATE 115200 → DIV 54; `sample_tick` first at cycle 53 after reset, then every 54 cycles.
- Assert `rst` with 5 entries stored → `count` 0 and `rd_valid` 0 asynchronously; the next write of 0x61 reads back 0x61.
- LINE_MODE: write 'a', 'b', 0x08, 'c', 0x0D → `rd_valid` 0 until 0x0D stored, then reads 'a', 'c', 0x0D.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Groups the byte path between the UART receive datapath, the receive
// buffer controller and the CPU-side consumer.
//
//   rx_done   datapath -> ctrl   one-cycle pulse, byte complete
//   rx_data   datapath -> ctrl   received byte, valid with rx_done
//   rd_valid  ctrl -> consumer   head byte available
//   rd_ready  consumer -> ctrl   consumer accepts head byte
//   rd_data   ctrl -> consumer   head byte (show-ahead)
//   count     ctrl -> consumer   number of stored bytes
//   full      ctrl -> consumer   count == DEPTH
//   overflow  ctrl -> consumer   sticky, a byte was dropped
//   ovf_clr   consumer -> ctrl   one-cycle pulse clearing overflow
//
// Modports: master = the buffer controller, slave = its environment.
// ----------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 32
);
    logic                       rx_done;
    logic [7:0]                 rx_data;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [7:0]                 rd_data;
    logic [$clog2(DEPTH):0]     count;
    logic                       full;
    logic                       overflow;
    logic                       ovf_clr;

    modport master (
        input  rx_done, rx_data, rd_ready, ovf_clr,
        output rd_valid, rd_data, count, full, overflow
    );

    modport slave (
        output rx_done, rx_data, rd_ready, ovf_clr,
        input  rd_valid, rd_data, count, full, overflow
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side controller for the keyboard/serial input path.
//  - Generates a 16x-baud sample tick for the receive datapath.
//  - Captures completed bytes into a DEPTH-entry circular buffer.
//  - Presents the head byte to the consumer over valid/ready (show-ahead).
//  - Tracks occupancy and a sticky overflow flag.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sample_tick  one-cycle pulse at 16x BAUD_RATE
//   bus          uart_rx_ctrl_if.master (rx_done/rx_data in, rd_* handshake,
//                count/full/overflow status, ovf_clr)
//
// Optional feature: define UART_RX_CTRL_LINE_MODE_EN to deliver only whole
// lines (terminated by 0x0D) and to apply 0x08 as an in-buffer backspace.
// Without it every byte is stored and rd_valid = !empty.
// ----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DEPTH     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            sample_tick,
    uart_rx_ctrl_if.master  bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CNTW    = AW + 1;
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_BS = 8'h08;

    // ------------------------------------------------------------------
    // 16x oversample tick divider
    // ------------------------------------------------------------------
    logic [DW-1:0] div_cnt_reg, div_cnt_next;

    always_comb begin
        div_cnt_next = div_cnt_reg + DW'(1);
        if (div_cnt_reg == DW'(DIV - 1)) begin
            div_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    assign sample_tick = (div_cnt_reg == DW'(DIV - 1));

    // ------------------------------------------------------------------
    // Circular buffer state
    // ------------------------------------------------------------------
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNTW-1:0] count_reg, count_next;
    logic            overflow_reg, overflow_next;

    logic            empty;
    logic            full;
    logic            rd_valid;
    logic [7:0]      head_data;
    logic            pop;
    logic            store_req;
    logic            wr_en;
    logic            ovf_set;
    logic            bs_remove;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNTW'(DEPTH));
    assign head_data = mem[rd_ptr_reg];
    assign pop       = rd_valid && bus.rd_ready;

`ifdef UART_RX_CTRL_LINE_MODE_EN
    logic [CNTW-1:0] line_cnt_reg, line_cnt_next;
    logic [7:0]      tail_data;
    logic            rx_is_bs;

    assign tail_data = mem[wr_ptr_reg - AW'(1)];
    assign rx_is_bs  = (bus.rx_data == CHAR_BS);

    // The full term lets an overlong line drain instead of deadlocking.
    assign rd_valid  = !empty && ((line_cnt_reg != '0) || full);

    always_comb begin
        store_req = bus.rx_done && !rx_is_bs;
        // Backspace never crosses a line terminator already stored.
        bs_remove = bus.rx_done && rx_is_bs && !empty && (tail_data != CHAR_CR);
    end

    always_comb begin
        line_cnt_next = line_cnt_reg;
        if (wr_en && (bus.rx_data == CHAR_CR)) begin
            line_cnt_next = line_cnt_next + CNTW'(1);
        end
        if (pop && (head_data == CHAR_CR)) begin
            line_cnt_next = line_cnt_next - CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt_reg <= '0;
        end else begin
            line_cnt_reg <= line_cnt_next;
        end
    end
`else
    assign rd_valid = !empty;

    always_comb begin
        store_req = bus.rx_done;
        bs_remove = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Next-state for pointers, occupancy and overflow
    // ------------------------------------------------------------------
    always_comb begin
        // A same-cycle pop frees the slot the write needs when full.
        wr_en   = store_req && (!full || pop);
        ovf_set = store_req && full && !pop;

        // wr_en and bs_remove are mutually exclusive (0x08 is never stored).
        wr_ptr_next = wr_ptr_reg + AW'(wr_en) - AW'(bs_remove);
        rd_ptr_next = rd_ptr_reg + AW'(pop);
        count_next  = count_reg + CNTW'(wr_en) - CNTW'(pop) - CNTW'(bs_remove);

        overflow_next = overflow_reg;
        if (ovf_set) begin
            overflow_next = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared. Writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_reg] <= bus.rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = head_data;
    assign bus.count    = count_reg;
    assign bus.full     = full;
    assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    localparam int DEPTH    = 32;
    localparam int EXP_DIV  = 54;   // 100e6 / (115200*16) = 54.25 -> 54

    logic clk;
    logic rst;
    logic sample_tick;

    uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_ctrl #(
        .CLK_FREQ  (100_000_000),
        .BAUD_RATE (115200),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end else begin
            pass_cnt++;
            $display("ok   %s: 0x%0h", name, got);
        end
    endtask

    // Drive inputs for one cycle starting just after a rising edge; returns
    // just after the next rising edge with inputs deasserted.
    task automatic cyc(input logic rxd, input logic [7:0] data, input logic rdy, input logic clr);
        bus.rx_done  = rxd;
        bus.rx_data  = data;
        bus.rd_ready = rdy;
        bus.ovf_clr  = clr;
        @(posedge clk);
        #1;
        bus.rx_done  = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rd_ready = 1'b0;
        bus.ovf_clr  = 1'b0;
    endtask

    // Inputs applied during a cycle; expected outputs seen in that same
    // cycle (all outputs come from registered state).
    typedef struct {
        logic       rx_done;
        logic [7:0] rx_data;
        logic       rd_ready;
        logic       ovf_clr;
        logic       exp_valid;
        logic       chk_data;
        logic [7:0] exp_data;
        logic [5:0] exp_count;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int tick_err;
        int tick_num;

        bus.rx_done  = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rd_ready = 1'b0;
        bus.ovf_clr  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_tick",  32'(sample_tick),   32'd0);
        chk("rst_valid", 32'(bus.rd_valid),  32'd0);
        chk("rst_count", 32'(bus.count),     32'd0);
        chk("rst_full",  32'(bus.full),      32'd0);
        chk("rst_ovf",   32'(bus.overflow),  32'd0);

        // Tick divider: sample k=0 is the first cycle after release.
        rst = 1'b0;
        tick_err = 0;
        tick_num = 0;
        for (int k = 0; k < 200; k++) begin
            if (sample_tick !== ((k % EXP_DIV) == EXP_DIV - 1)) tick_err++;
            if (sample_tick === 1'b1) tick_num++;
            if (k == 53)  chk("tick_first",  32'(sample_tick), 32'd1);
            if (k == 107) chk("tick_second", 32'(sample_tick), 32'd1);
            @(negedge clk);
        end
        chk("tick_pattern_errors", 32'(tick_err), 32'd0);
        chk("tick_count_200", 32'(tick_num), 32'd3);

        @(posedge clk);
        #1;

`ifdef UART_RX_CTRL_LINE_MODE_EN
        // Backspace on empty buffer is discarded without overflow.
        cyc(1'b1, 8'h08, 1'b0, 1'b0);
        chk("lm_bs_empty_count", 32'(bus.count), 32'd0);
        chk("lm_bs_empty_ovf",   32'(bus.overflow), 32'd0);
        cyc(1'b1, 8'h61, 1'b0, 1'b0);
        chk("lm_a_count", 32'(bus.count), 32'd1);
        chk("lm_a_valid", 32'(bus.rd_valid), 32'd0);
        cyc(1'b1, 8'h62, 1'b0, 1'b0);
        chk("lm_b_count", 32'(bus.count), 32'd2);
        chk("lm_b_valid", 32'(bus.rd_valid), 32'd0);
        cyc(1'b1, 8'h08, 1'b0, 1'b0);
        chk("lm_bs_count", 32'(bus.count), 32'd1);
        chk("lm_bs_valid", 32'(bus.rd_valid), 32'd0);
        cyc(1'b1, 8'h63, 1'b0, 1'b0);
        chk("lm_c_count", 32'(bus.count), 32'd2);
        chk("lm_c_valid", 32'(bus.rd_valid), 32'd0);
        cyc(1'b1, 8'h0D, 1'b0, 1'b0);
        chk("lm_cr_count", 32'(bus.count), 32'd3);
        chk("lm_cr_valid", 32'(bus.rd_valid), 32'd1);
        chk("lm_rd0", 32'(bus.rd_data), 32'h61);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lm_rd1", 32'(bus.rd_data), 32'h63);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lm_rd2", 32'(bus.rd_data), 32'h0D);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lm_end_count", 32'(bus.count), 32'd0);
        chk("lm_end_valid", 32'(bus.rd_valid), 32'd0);
`else
        // Table: three writes then three back-to-back pops.
        //           rxd   data   rdy   clr   valid chkd  edata  cnt   full  ovf
        vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 6'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 6'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 6'd3, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h42, 6'd2, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h43, 6'd1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};

        for (int i = 0; i < 7; i++) begin
            bus.rx_done  = vecs[i].rx_done;
            bus.rx_data  = vecs[i].rx_data;
            bus.rd_ready = vecs[i].rd_ready;
            bus.ovf_clr  = vecs[i].ovf_clr;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
            @(posedge clk);
            #1;
        end
        bus.rx_done  = 1'b0;
        bus.rd_ready = 1'b0;

        // rd_ready while empty is ignored (vec6 popped on empty).
        chk("empty_pop_count", 32'(bus.count), 32'd0);

        // Fill to full, then overflow.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full",  32'(bus.full),     32'd1);
        chk("fill_count", 32'(bus.count),    32'd32);
        chk("fill_ovf",   32'(bus.overflow), 32'd0);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_set",   32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count),    32'd32);
        // Set and clear together: set wins.
        cyc(1'b1, 8'hFE, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d", i), 32'(bus.rd_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_count",  32'(bus.count),    32'd0);
        chk("drain_valid",  32'(bus.rd_valid), 32'd0);
        chk("ovf_sticky",   32'(bus.overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        // Simultaneous write and pop at full.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("wp_full_count", 32'(bus.count),    32'd32);
        chk("wp_full_ovf",   32'(bus.overflow), 32'd0);
        chk("wp_full_full",  32'(bus.full),     32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            chk($sformatf("wp_drain%0d", i), 32'(bus.rd_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("wp_last", 32'(bus.rd_data), 32'h55);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wp_empty", 32'(bus.rd_valid), 32'd0);

        // Asynchronous reset with entries stored.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count),    32'd0);
        chk("arst_valid", 32'(bus.rd_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 8'h61, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(bus.rd_valid), 32'd1);
        chk("post_rst_data",  32'(bus.rd_data),  32'h61);
        chk("post_rst_count", 32'(bus.count),    32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
